ycbcr2rgb_pipe: RTL and testbench
=================================

Name: ycbcr2rgb_pipe

Overview:
- Inverse colour-space converter: takes 8-bit BT.601 studio-range Y/Cb/Cr samples and produces 8-bit R/G/B.
- Sits at the display end of the video path, after the RGB-to-YCbCr encoder and any YCbCr-domain processing.
- 3-stage fixed-point pipeline, Q8 coefficients, with a valid/ready handshake and full backpressure support.

Parameters:
- CLAMP_LO, 0, minimum output code per component (inclusive).
- CLAMP_HI, 255, maximum output code per component (inclusive); must satisfy CLAMP_LO <= CLAMP_HI <= 255.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  y/cb/cr hold a valid sample.
- in_ready  output  1  block accepts a sample this cycle.
- y  input  8  luma, unsigned.
- cb  input  8  blue-difference chroma, unsigned, 128 = zero.
- cr  input  8  red-difference chroma, unsigned, 128 = zero.
- out_valid  output  1  r/g/b hold a valid pixel.
- out_ready  input  1  downstream accepts the pixel.
- r  output  8  red.
- g  output  8  green.
- b  output  8  blue.

Behaviour:
- Reset (async assert, sync-safe deassert): all stage valids = 0, out_valid = 0, r = g = b = 0, all pipeline data registers = 0.
- Reset mid-operation flushes every in-flight sample. No partial pixel may emerge after reset release.
- Advance enable: adv = ~out_valid | out_ready. in_ready = adv, combinational. All stages shift together only when adv = 1.
- Stall: when adv = 0, all stage registers and r/g/b/out_valid hold.
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Bubbles: stage valid bits propagate with the data. Bubbles travel through the pipe and are not collapsed.
- Stage 1 (offset):
  - yo = y - 16, signed 9-bit.
  - cbo = cb - 128, signed 9-bit.
  - cro = cr - 128, signed 9-bit.
- Stage 2 (multiply), signed 20-bit products:
  - py = 298*yo
  - prc = 409*cro
  - pgc = 208*cro
  - pgb = 100*cbo
  - pbb = 516*cbo
- Stage 3 (sum, round, clamp):
  - sr = py + prc + 128
  - sg = py - pgc - pgb + 128
  - sb = py + pbb + 128
  - Sums are signed 20-bit, followed by an arithmetic shift right by 8.
  - Clamp: result < CLAMP_LO gives CLAMP_LO; result > CLAMP_HI gives CLAMP_HI; otherwise the low 8 bits.
  - The stage 3 result registers directly into r/g/b with out_valid.
- Latency: exactly 3 cycles from input transfer to out_valid when out_ready is held at 1.
- Throughput: 1 pixel/cycle when out_ready is held at 1.
- Simultaneous input and output transfer in the same cycle is legal and loses no sample.
- Data stability: r/g/b must not change while out_valid = 1 and out_ready = 0.
- Out-of-range inputs: Y < 16 or Y > 235, and chroma outside 16..240, are processed arithmetically with no special casing. Only the clamp bounds the output.
- Input data is ignored when in_valid = 0.

Optional Feature:
- Macro: YCC2RGB_SAT_FLAG_EN.
- Defined:
  - Adds output port sat (1 bit), pipelined alongside r/g/b.
  - sat = 1 when any component was clamped for that pixel.
  - Held under stall; reset value 0.
- Undefined: port sat and its register are absent. The rest of the behaviour is identical.

Test Plan:
- Reset then single sample Y=16, Cb=128, Cr=128, out_ready=1 -> out_valid rises exactly 3 cycles after transfer, r=g=b=0, sat=0.
- Y=235, Cb=128, Cr=128 -> r=g=b=255, sat=0. Y=126, Cb=128, Cr=128 -> r=g=b=128.
- Y=235, Cb=128, Cr=240 -> r=255 (clamped from 434), g=164, b=255, sat=1.
- Y=16, Cb=16, Cr=16 -> r=0 (clamped), g=135, b=0 (clamped), sat=1.
- Backpressure:
  - Stimulus: stream 10 distinct samples back-to-back, toggle out_ready 1/0 pseudo-randomly.
  - Required: all 10 pixels emerge in order, none dropped or duplicated; r/g/b stable during every stall; in_ready = 0 exactly when out_valid & ~out_ready.
- Reset mid-operation:
  - Stimulus: assert rst with 3 samples in flight and out_ready=0.
  - Required: out_valid=0 and r=g=b=0 immediately; after release, no stale pixel appears, and the next sample emerges after 3 cycles.

Source files
------------

// File: rtl/ycbcr2rgb_pipe.sv
// ycbcr2rgb_pipe
// Converts 8-bit BT.601 studio-range Y/Cb/Cr samples to 8-bit R/G/B.
// It is a three-stage fixed-point pipeline with Q8 coefficients:
//   stage 1  removes the offsets (Y-16, Cb-128, Cr-128)
//   stage 2  forms the five coefficient products
//   stage 3  sums, rounds, shifts right by 8 and clamps into r/g/b
// A valid/ready handshake with full backpressure controls the pipe. All
// stages advance together, and only when the output register is empty or is
// being drained.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   y/cb/cr carry a sample          in_ready   sample accepted this cycle
//   y, cb, cr  8-bit unsigned inputs (chroma is offset by 128)
//   out_valid  r/g/b carry a pixel             out_ready  downstream takes the pixel
//   r, g, b    8-bit clamped outputs
//   sat        present only when YCC2RGB_SAT_FLAG_EN is defined; it is set
//              when any component of the pixel was clamped
//
// Parameters
//   CLAMP_LO / CLAMP_HI  inclusive output code range, 0 <= LO <= HI <= 255

module ycbcr2rgb_pipe #(
    parameter int CLAMP_LO = 0,
    parameter int CLAMP_HI = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] y,
    input  logic [7:0] cb,
    input  logic [7:0] cr,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b
`ifdef YCC2RGB_SAT_FLAG_EN
    ,
    output logic       sat
`endif
);

    function automatic logic [7:0] clamp8(input logic signed [11:0] v);
        if (int'(v) < CLAMP_LO)      return 8'(CLAMP_LO);
        else if (int'(v) > CLAMP_HI) return 8'(CLAMP_HI);
        else                         return v[7:0];
    endfunction

`ifdef YCC2RGB_SAT_FLAG_EN
    function automatic logic is_clamped(input logic signed [11:0] v);
        return (int'(v) < CLAMP_LO) || (int'(v) > CLAMP_HI);
    endfunction
`endif

    logic w_adv;

    logic              r_s1_valid;
    logic signed [8:0] r_yo, r_cbo, r_cro;
    logic signed [8:0] w_yo, w_cbo, w_cro;

    logic               r_s2_valid;
    logic signed [19:0] r_py, r_prc, r_pgc, r_pgb, r_pbb;

    logic signed [19:0] w_sr, w_sg, w_sb;
    logic signed [11:0] w_rs, w_gs, w_bs;

    logic       r_out_valid;
    logic [7:0] r_red, r_grn, r_blu;

    // The output register is free when it is empty or is being drained this
    // cycle. When it is free, every stage shifts forward by one.
    assign w_adv    = ~r_out_valid | out_ready;
    assign in_ready = w_adv;

    assign w_yo  = $signed({1'b0, y})  - 9'sd16;
    assign w_cbo = $signed({1'b0, cb}) - 9'sd128;
    assign w_cro = $signed({1'b0, cr}) - 9'sd128;

    // The +128 rounds to nearest before the divide by 256. Bits [19:8] hold the
    // arithmetic shift exactly, because every reachable sum fits in 20 bits.
    assign w_sr = r_py + r_prc + 20'sd128;
    assign w_sg = r_py - r_pgc - r_pgb + 20'sd128;
    assign w_sb = r_py + r_pbb + 20'sd128;
    assign w_rs = w_sr[19:8];
    assign w_gs = w_sg[19:8];
    assign w_bs = w_sb[19:8];

    // A bubble still moves the valid bits forward. The data registers load
    // only behind a valid sample, so r/g/b keep the last pixel across bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid  <= 1'b0;
            r_yo        <= '0;
            r_cbo       <= '0;
            r_cro       <= '0;
            r_s2_valid  <= 1'b0;
            r_py        <= '0;
            r_prc       <= '0;
            r_pgc       <= '0;
            r_pgb       <= '0;
            r_pbb       <= '0;
            r_out_valid <= 1'b0;
            r_red       <= '0;
            r_grn       <= '0;
            r_blu       <= '0;
        end else if (w_adv) begin
            r_s1_valid  <= in_valid;
            r_s2_valid  <= r_s1_valid;
            r_out_valid <= r_s2_valid;
            if (in_valid) begin
                r_yo  <= w_yo;
                r_cbo <= w_cbo;
                r_cro <= w_cro;
            end
            if (r_s1_valid) begin
                r_py  <= r_yo  * 20'sd298;
                r_prc <= r_cro * 20'sd409;
                r_pgc <= r_cro * 20'sd208;
                r_pgb <= r_cbo * 20'sd100;
                r_pbb <= r_cbo * 20'sd516;
            end
            if (r_s2_valid) begin
                r_red <= clamp8(w_rs);
                r_grn <= clamp8(w_gs);
                r_blu <= clamp8(w_bs);
            end
        end
    end

`ifdef YCC2RGB_SAT_FLAG_EN
    logic r_sat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sat <= 1'b0;
        end else if (w_adv && r_s2_valid) begin
            r_sat <= is_clamped(w_rs) | is_clamped(w_gs) | is_clamped(w_bs);
        end
    end

    assign sat = r_sat;
`endif

    assign out_valid = r_out_valid;
    assign r         = r_red;
    assign g         = r_grn;
    assign b         = r_blu;

endmodule

// File: tb/tb_ycbcr2rgb_pipe.sv
module tb_ycbcr2rgb_pipe;

    localparam int LO = 0;
    localparam int HI = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] y = '0, cb = '0, cr = '0;
    logic       in_ready, out_valid;
    logic [7:0] r, g, b;
    logic       sat_obs;

`ifdef YCC2RGB_SAT_FLAG_EN
    logic sat;
    assign sat_obs = sat;
`else
    assign sat_obs = 1'b0;
`endif

    ycbcr2rgb_pipe #(.CLAMP_LO(LO), .CLAMP_HI(HI)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .cb(cb), .cr(cr),
        .out_valid(out_valid), .out_ready(out_ready),
        .r(r), .g(g), .b(b)
`ifdef YCC2RGB_SAT_FLAG_EN
        , .sat(sat)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [24:0] exp_q[$];
    bit          mon_en = 0;
    bit          rand_rdy = 0;
    bit          prev_stall = 0;
    logic [23:0] prev_rgb = '0;

    function automatic int clampi(input int v);
        if (v < LO) return LO;
        if (v > HI) return HI;
        return v;
    endfunction

    // Reference model: returns {sat, r, g, b}
    function automatic logic [24:0] model(input int yy, input int cbv, input int crv);
        int yo, cbo, cro, vr, vg, vb;
        logic s;
        yo  = yy - 16;
        cbo = cbv - 128;
        cro = crv - 128;
        vr  = (298 * yo + 409 * cro + 128) >>> 8;
        vg  = (298 * yo - 208 * cro - 100 * cbo + 128) >>> 8;
        vb  = (298 * yo + 516 * cbo + 128) >>> 8;
`ifdef YCC2RGB_SAT_FLAG_EN
        s = (vr < LO) || (vr > HI) || (vg < LO) || (vg > HI) || (vb < LO) || (vb > HI);
`else
        s = 1'b0;
`endif
        return {s, 8'(clampi(vr)), 8'(clampi(vg)), 8'(clampi(vb))};
    endfunction

    // Output-side monitor: checks handshake, stall stability and pixel order.
    always @(negedge clk) begin
        logic [24:0] e;
        if (mon_en && rst) begin
            n_cmp++;
            assert (in_ready === !(out_valid && !out_ready)) else begin
                n_err++;
                $error("FAIL in_ready: got %b want %b", in_ready, !(out_valid && !out_ready));
            end
            if (prev_stall) begin
                n_cmp++;
                assert ({out_valid, r, g, b} === {1'b1, prev_rgb}) else begin
                    n_err++;
                    $error("FAIL stall_hold: got v=%b rgb=%h want v=1 rgb=%h", out_valid, {r, g, b}, prev_rgb);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL extra_pixel: got rgb=%h want no pixel", {r, g, b});
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    assert ({sat_obs, r, g, b} === e) else begin
                        n_err++;
                        $error("FAIL pixel: got sat=%b rgb=%h want sat=%b rgb=%h",
                               sat_obs, {r, g, b}, e[24], e[23:0]);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_rgb   = {r, g, b};
        end else begin
            prev_stall = 0;
        end
    end

    task automatic send(input int yy, input int cbv, input int crv);
        bit done;
        done = 0;
        in_valid = 1'b1;
        y  = 8'(yy);
        cb = 8'(cbv);
        cr = 8'(crv);
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(yy, cbv, crv));
                done = 1;
            end
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        n_cmp++;
        assert (done) else begin
            n_err++;
            $error("FAIL send_timeout: got accepted=%b want 1", done);
        end
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL drain_%s: got %0d pending want 0", tag, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_latency(input string tag);
        int lat;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        n_cmp++;
        assert (lat === 3) else begin
            n_err++;
            $error("FAIL latency_%s: got %0d want 3", tag, lat);
        end
    endtask

    int y_tab[10]  = '{16, 235, 126, 60, 200, 100, 16, 180, 30, 250};
    int cb_tab[10] = '{128, 128, 128, 90, 200, 240, 16, 50, 160, 5};
    int cr_tab[10] = '{128, 128, 240, 100, 60, 16, 16, 220, 30, 250};

    initial begin
        bit stale;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        assert (out_valid === 1'b0) else begin
            n_err++; $error("FAIL rst_out_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        assert ({r, g, b} === 24'h0) else begin
            n_err++; $error("FAIL rst_rgb: got %h want 000000", {r, g, b});
        end
        n_cmp++;
        assert (sat_obs === 1'b0) else begin
            n_err++; $error("FAIL rst_sat: got %b want 0", sat_obs);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        mon_en = 1;

        send(16, 128, 128);
        check_latency("first");
        drain("first");

        send(235, 128, 128);
        send(126, 128, 128);
        send(235, 128, 240);
        send(16, 16, 16);
        drain("directed");

        rand_rdy = 1;
        for (int i = 0; i < 10; i++) send(y_tab[i], cb_tab[i], cr_tab[i]);
        rand_rdy = 0;
        drain("backpressure");

        out_ready = 1'b0;
        send(50, 100, 150);
        send(70, 110, 140);
        send(90, 120, 130);
        mon_en = 0;
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        assert (out_valid === 1'b0) else begin
            n_err++; $error("FAIL midrst_out_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        assert ({r, g, b} === 24'h0) else begin
            n_err++; $error("FAIL midrst_rgb: got %h want 000000", {r, g, b});
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) stale = 1;
        end
        n_cmp++;
        assert (stale === 1'b0) else begin
            n_err++; $error("FAIL stale_pixel: got out_valid seen=%b want 0", stale);
        end
        @(posedge clk);
        #1;
        mon_en = 1;
        send(100, 90, 200);
        check_latency("after_reset");
        drain("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
